rram_array_sequencer: RTL
=========================

Name: rram_array_sequencer

Overview:
- Parametrised next-generation RRAM crossbar controller: accepts 32-bit instructions (WRITE/READ/MAC/NOP) over a valid/ready handshake and sequences the WL/BL/SL driver codes, enables, precharge, CSA and ADC strobes through an explicit FSM.
- Returns read and MAC results over a second valid/ready handshake.
- Sits between the instruction/input buffers and the analog array macro; replaces fixed-size, halt-driven sequencing with programmable pulse and sense timing.

Parameters:
- ARRAY_SIZE, 16, rows = columns of the crossbar
- ADDR_W, 4, row/column address width (clog2 ARRAY_SIZE, ≤8)
- ADC_BITS, 3, ADC code bits per column
- WR_PULSE_DEF, 4, write-pulse cycles used when instruction pulse field = 0
- SENSE_CYC, 2, cycles CSA/ADC evaluation is held
- PRE_CYC, 1, precharge cycles before sense/evaluate

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ins_valid  in  1  instruction valid
- ins_ready  out  1  sequencer accepts instruction
- ins_data  in  32  [31:28] opcode (0 NOP, 1 WRITE, 2 READ, 3 MAC), [ADDR_W-1:0] col / MAC vector count-1 (8 bits), [8+ADDR_W-1:8] row, [16] write data, [27:20] pulse cycles
- vec_valid  in  1  MAC input vector valid
- vec_ready  out  1  vector consumed
- vec_data  in  ARRAY_SIZE  MAC input vector (bit i drives WL i)
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  ARRAY_SIZE*ADC_BITS  READ: CSA zero-extended; MAC: ADC codes
- CSA  in  ARRAY_SIZE  sense-amp outputs
- ADC_CODE  in  ARRAY_SIZE*ADC_BITS  ADC outputs, column i at [i*ADC_BITS +: ADC_BITS]
- IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL  out  ARRAY_SIZE each  line driver codes
- ENABLE_WL, ENABLE_BL, ENABLE_SL, PRE, SAEN_CSA, CLK_EN_ADC  out  1 each  array strobes
- busy  out  1  FSM not in IDLE
- err  out  1  sticky: unknown opcode received

Behaviour:
- Reset (async, rst=0): state IDLE; all driver codes all-ones (ground pattern 11); enables, SAEN_CSA, CLK_EN_ADC = 0; PRE = 1 (precharge off); res_valid, vec_ready, busy, err = 0; ins_ready = 1 once rst deasserts. Reset mid-operation aborts immediately; no result is emitted.
- All outputs are registered. Instruction accepted on clk edge with ins_valid & ins_ready; ins_ready = 1 only in IDLE.
- Driver codes: selected write WL = 01 (IN0=0, IN1=1); read-selected WL = 00; ground = 11.
  - SET (data=1): selected BL = 00, all SL = 11.
  - RESET: selected SL = 01, all BL = 11.
  - Read/MAC: all BL = 01, all SL = 11.
  - MAC WL i = 01 if vec bit i = 1, else 11.
- WRITE: WR_SETUP (1 cycle, codes applied, enables 0) → WR_PULSE (N cycles, ENABLE_WL/BL/SL = 1; N = pulse field, or WR_PULSE_DEF if 0) → WR_RECOVER (1 cycle, enables 0, codes back to 11) → IDLE. No result.
- READ: RD_PRE (PRE_CYC cycles, PRE = 0, codes applied) → RD_SENSE (SENSE_CYC cycles, PRE = 1, ENABLE_WL/BL = 1, SAEN_CSA = 1; CSA sampled on last cycle) → RD_OUT (res_valid = 1, hold until res_ready) → IDLE.
- MAC: MAC_WAIT (vec_ready = 1 until vec_valid; vector latched) → MAC_PRE (PRE_CYC) → MAC_EVAL (SENSE_CYC cycles, ENABLE_WL/BL = 1, CLK_EN_ADC = 1; ADC_CODE sampled on last cycle) → MAC_OUT (hold until res_ready).
  - Then decrement the remaining count: nonzero → MAC_WAIT; zero → IDLE.
  - Total vectors processed = count field + 1 (1..256).
- res_data and res_valid are stable while res_valid=1 & res_ready=0. res_valid drops the cycle after acceptance.
- NOP: accepted, no state change. Unknown opcode (4..15): accepted, dropped, err set until reset.
- Row/col ≥ ARRAY_SIZE: no line selected (all ground); the operation is still timed.

Test Plan:
- WRITE SET row 3 col 5, pulse field 0: WR_PULSE lasts exactly 4 cycles; IN0_WL[3]=0, IN1_WL[3]=1; BL[5]=00; all other lines 11; busy high for 6 cycles total.
- WRITE RESET row 0 col 15, pulse field 10: SL[15]=01, BL all 11; enables high for exactly 10 cycles; ins_ready low throughout.
- READ row 7 with CSA=16'hA5C3, res_ready held low 5 cycles: WL[7]=00; res_data=A5C3 held stable; res_valid drops one cycle after res_ready.
- MAC, count field=2, vectors 16'h0001/16'hFFFF/16'h0000 with vec_valid gaps: exactly 3 results, each equal to ADC_CODE during its eval cycle; WL patterns match vectors; FSM returns to IDLE.
- Opcode 4'h9 then READ: err=1 and stays set; READ completes normally.
- rst asserted mid-WR_PULSE and mid-MAC_OUT: enables drop asynchronously; all codes 11; no res_valid after release.

Source files
------------

// File: rtl/rram_array_sequencer.sv
// rtl/rram_array_sequencer.sv - RRAM crossbar instruction sequencer
// Decodes WRITE/READ/MAC/NOP instructions into timed driver codes and strobes.
module rram_array_sequencer #(
  parameter int ARRAY_SIZE   = 16,
  parameter int ADDR_W       = 4,
  parameter int ADC_BITS     = 3,
  parameter int WR_PULSE_DEF = 4,
  parameter int SENSE_CYC    = 2,
  parameter int PRE_CYC      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  input  logic [31:0]                    ins_data,
  input  logic                           vec_valid,
  output logic                           vec_ready,
  input  logic [ARRAY_SIZE-1:0]          vec_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ARRAY_SIZE*ADC_BITS-1:0] res_data,
  input  logic [ARRAY_SIZE-1:0]          CSA,
  input  logic [ARRAY_SIZE*ADC_BITS-1:0] ADC_CODE,
  output logic [ARRAY_SIZE-1:0]          IN0_WL,
  output logic [ARRAY_SIZE-1:0]          IN1_WL,
  output logic [ARRAY_SIZE-1:0]          IN0_BL,
  output logic [ARRAY_SIZE-1:0]          IN1_BL,
  output logic [ARRAY_SIZE-1:0]          IN0_SL,
  output logic [ARRAY_SIZE-1:0]          IN1_SL,
  output logic                           ENABLE_WL,
  output logic                           ENABLE_BL,
  output logic                           ENABLE_SL,
  output logic                           PRE,
  output logic                           SAEN_CSA,
  output logic                           CLK_EN_ADC,
  output logic                           busy,
  output logic                           err
);
  localparam int RW = ARRAY_SIZE * ADC_BITS;
  localparam logic [ARRAY_SIZE-1:0] ONE = 1;
  localparam logic [3:0] OP_NOP = 4'd0, OP_WRITE = 4'd1, OP_READ = 4'd2, OP_MAC = 4'd3;

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_RECOVER, RD_PRE, RD_SENSE, RD_OUT,
    MAC_WAIT, MAC_PRE, MAC_EVAL, MAC_OUT
  } state_t;

  state_t state, state_n;
  logic [7:0] cnt, cnt_n, left, left_n;
  logic [ADDR_W-1:0] row, row_n, col, col_n;
  logic wdata, wdata_n, err_n;
  logic [ARRAY_SIZE-1:0] vec, vec_n, row_oh, col_oh;
  logic [RW-1:0] res_n;
  logic [ARRAY_SIZE-1:0] in0_wl_n, in1_wl_n, in0_bl_n, in1_bl_n, in0_sl_n, in1_sl_n;
  logic en_wl_n, en_bl_n, en_sl_n, pre_n, saen_n, adc_n;
  logic unused_bits;

  assign unused_bits = ^ins_data;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    left_n  = left;
    row_n   = row;
    col_n   = col;
    wdata_n = wdata;
    vec_n   = vec;
    res_n   = res_data;
    err_n   = err;
    case (state)
      IDLE: if (ins_valid && ins_ready) begin
        row_n   = ins_data[8 +: ADDR_W];
        col_n   = ins_data[0 +: ADDR_W];
        wdata_n = ins_data[16];
        case (ins_data[31:28])
          OP_NOP: ;
          OP_WRITE: begin
            state_n = WR_SETUP;
            cnt_n   = (ins_data[27:20] == 8'd0) ? 8'(WR_PULSE_DEF - 1) : ins_data[27:20] - 8'd1;
          end
          OP_READ: begin
            state_n = RD_PRE;
            cnt_n   = 8'(PRE_CYC - 1);
          end
          OP_MAC: begin
            state_n = MAC_WAIT;
            left_n  = ins_data[7:0];
          end
          default: err_n = 1'b1;
        endcase
      end
      WR_SETUP:   state_n = WR_PULSE;
      WR_PULSE:   if (cnt == 8'd0) state_n = WR_RECOVER; else cnt_n = cnt - 8'd1;
      WR_RECOVER: state_n = IDLE;
      RD_PRE: if (cnt == 8'd0) begin
        state_n = RD_SENSE;
        cnt_n   = 8'(SENSE_CYC - 1);
      end else cnt_n = cnt - 8'd1;
      RD_SENSE: if (cnt == 8'd0) begin
        state_n = RD_OUT;
        res_n   = '0;
        res_n[ARRAY_SIZE-1:0] = CSA;
      end else cnt_n = cnt - 8'd1;
      RD_OUT: if (res_valid && res_ready) state_n = IDLE;
      MAC_WAIT: if (vec_valid && vec_ready) begin
        vec_n   = vec_data;
        state_n = MAC_PRE;
        cnt_n   = 8'(PRE_CYC - 1);
      end
      MAC_PRE: if (cnt == 8'd0) begin
        state_n = MAC_EVAL;
        cnt_n   = 8'(SENSE_CYC - 1);
      end else cnt_n = cnt - 8'd1;
      MAC_EVAL: if (cnt == 8'd0) begin
        state_n = MAC_OUT;
        res_n   = ADC_CODE;
      end else cnt_n = cnt - 8'd1;
      MAC_OUT: if (res_valid && res_ready) begin
        if (left == 8'd0) state_n = IDLE;
        else begin
          left_n  = left - 8'd1;
          state_n = MAC_WAIT;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they can be registered.
    row_oh = (32'(row_n) < ARRAY_SIZE) ? (ONE << row_n) : '0;
    col_oh = (32'(col_n) < ARRAY_SIZE) ? (ONE << col_n) : '0;
    in0_wl_n = '1;
    in1_wl_n = '1;
    in0_bl_n = '1;
    in1_bl_n = '1;
    in0_sl_n = '1;
    in1_sl_n = '1;
    en_wl_n  = 1'b0;
    en_bl_n  = 1'b0;
    en_sl_n  = 1'b0;
    pre_n    = 1'b1;
    saen_n   = 1'b0;
    adc_n    = 1'b0;
    case (state_n)
      WR_SETUP, WR_PULSE: begin
        in0_wl_n = ~row_oh;
        if (wdata_n) begin
          in0_bl_n = ~col_oh;
          in1_bl_n = ~col_oh;
        end else in0_sl_n = ~col_oh;
        en_wl_n = (state_n == WR_PULSE);
        en_bl_n = en_wl_n;
        en_sl_n = en_wl_n;
      end
      RD_PRE, RD_SENSE: begin
        in0_wl_n = ~row_oh;
        in1_wl_n = ~row_oh;
        in0_bl_n = '0;
        pre_n    = (state_n != RD_PRE);
        en_wl_n  = (state_n == RD_SENSE);
        en_bl_n  = en_wl_n;
        saen_n   = en_wl_n;
      end
      MAC_PRE, MAC_EVAL: begin
        in0_wl_n = ~vec_n;
        in0_bl_n = '0;
        pre_n    = (state_n != MAC_PRE);
        en_wl_n  = (state_n == MAC_EVAL);
        en_bl_n  = en_wl_n;
        adc_n    = en_wl_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      left       <= '0;
      row        <= '0;
      col        <= '0;
      wdata      <= 1'b0;
      vec        <= '0;
      ins_ready  <= 1'b1;
      vec_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      IN0_WL     <= '1;
      IN1_WL     <= '1;
      IN0_BL     <= '1;
      IN1_BL     <= '1;
      IN0_SL     <= '1;
      IN1_SL     <= '1;
      ENABLE_WL  <= 1'b0;
      ENABLE_BL  <= 1'b0;
      ENABLE_SL  <= 1'b0;
      PRE        <= 1'b1;
      SAEN_CSA   <= 1'b0;
      CLK_EN_ADC <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      left       <= left_n;
      row        <= row_n;
      col        <= col_n;
      wdata      <= wdata_n;
      vec        <= vec_n;
      ins_ready  <= (state_n == IDLE);
      vec_ready  <= (state_n == MAC_WAIT);
      res_valid  <= (state_n == RD_OUT) || (state_n == MAC_OUT);
      res_data   <= res_n;
      busy       <= (state_n != IDLE);
      err        <= err_n;
      IN0_WL     <= in0_wl_n;
      IN1_WL     <= in1_wl_n;
      IN0_BL     <= in0_bl_n;
      IN1_BL     <= in1_bl_n;
      IN0_SL     <= in0_sl_n;
      IN1_SL     <= in1_sl_n;
      ENABLE_WL  <= en_wl_n;
      ENABLE_BL  <= en_bl_n;
      ENABLE_SL  <= en_sl_n;
      PRE        <= pre_n;
      SAEN_CSA   <= saen_n;
      CLK_EN_ADC <= adc_n;
    end
  end
endmodule
